trace_buffer: RTL
=================

Name: trace_buffer

Overview:
- Synthesizable, parametrised successor to the nic8 simulation status monitor.
- Snapshots CPU state each clock into a circular on-chip trace memory:
  - NUM_REGS register channels (pc, ir, a, b, x, q by default), data bus, control bits, tick stamp.
- Optional change-only capture mode and step-limit halt request.
- Drained by a valid/ready read port (UART dumper or bench), so traces survive on hardware without $display.

Parameters:
- WIDTH, 8, bits per register channel and per dbus.
- NUM_REGS, 6, number of register channels; channel 0 = pc by convention.
- CTRL_W, 14, width of control-bit vector.
- DEPTH, 16, trace entries; power of two, >= 2.
- TICK_W, 16, tick-stamp/counter width.

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous active-high reset.
- regs, input, NUM_REGS*WIDTH, packed register channels; channel k = bits [k*WIDTH +: WIDTH].
- ctrl, input, CTRL_W, control bits of current cycle.
- dbus, input, WIDTH, data bus value.
- arm, input, 1, level; capture enabled while high.
- change_only, input, 1, 1 = capture only when regs or dbus differ from last captured entry.
- step_limit, input, TICK_W, 0 = unlimited; else halt after this many ticks.
- rd_ready, input, 1, consumer accepts head entry.
- rd_valid, output, 1, buffer non-empty.
- rd_data, output, TICK_W+CTRL_W+WIDTH+NUM_REGS*WIDTH, head entry {tick, ctrl, dbus, regs}.
- count, output, $clog2(DEPTH)+1, entries held.
- overflow, output, 1, sticky: an entry was overwritten.
- halt_req, output, 1, sticky: step limit reached.

Behaviour:
- Reset state:
  - Outputs: count=0, rd_valid=0, overflow=0, halt_req=0; rd_data is don't-care while rd_valid=0.
  - Internal: tick=0, pointers=0, first-capture flag set.
- Tick counter:
  - Increments every edge after reset; saturates at all-ones.
  - Sample stamp = tick value at the sampling edge. The first edge after reset is released stamps 0.
- Capture condition at an edge: arm && !halt_req && (step_limit==0 || tick<step_limit) && (!change_only || first || {regs,dbus} != last_captured).
- first:
  - Set by reset and on every arm 0->1 transition.
  - Cleared by a capture.
- last_captured:
  - Updated only on captures.
  - ctrl and tick are excluded from the change compare.
- Latency: an entry captured at edge n is visible on rd_data/rd_valid after edge n (FWFT head, no extra stage).
- Read:
  - Pop when rd_valid && rd_ready at an edge.
  - rd_data is held stable while rd_valid && !rd_ready.
- Full (count==DEPTH) with capture, no pop:
  - Oldest entry dropped; write proceeds; count stays DEPTH; overflow set.
- Full with capture and pop at the same edge:
  - Head popped, new entry written, count unchanged, no overflow.
- Empty with capture and pop: not possible, because rd_valid=0 suppresses the pop.
- Pointers wrap modulo DEPTH.
- Step limit:
  - At the edge where step_limit!=0 and tick==step_limit, halt_req sets.
  - The sample at that edge is not captured.
  - halt_req stays set until reset; later changes to step_limit have no effect.
- arm low mid-run: captures stop; buffer contents and read port keep working.
- reset mid-operation: buffer discarded (count=0) regardless of pending read; tick and sticky flags cleared.

Decomposition:
- Shared header nic8_trace_pkg:
  - Control-bit width constant (same as the `Control macro width).
  - Entry field offsets: TICK_LSB, CTRL_LSB, DBUS_LSB, REGS_LSB.
  - Entry width as a function of the parameters.
- Sub-module trace_ram: DEPTH x entry-width, one synchronous write port and one asynchronous read port.
- Top holds tick, pointers, count, compare and flag logic.

Test Plan:
- Reset, arm=1, change_only=0, step_limit=0, regs constant, rd_ready=0 for 5 edges -> count=5; first rd_data tick=0, last tick=4.
- DEPTH=16, 20 captures with no reads -> count=16, overflow=1; drained ticks run 4..19 in order.
- change_only=1, pc increments only on edges 0, 3, 7 (others constant) -> entries stamped at the arm edge plus ticks 0, 3, 7 only; ctrl toggles alone produce no entries.
- step_limit=10, arm=1 -> ticks 0..9 captured (count=10); halt_req=1 after edge with tick=10; no further captures.
- Buffer full, capture and rd_ready=1 simultaneously for 8 edges -> count stays 16, overflow stays 0, read ticks strictly increasing.
- Mid-stream reset with count=7 and rd_ready=1 -> next cycle count=0, rd_valid=0, overflow=0, halt_req=0, next stamp=0.

Source files
------------

// File: rtl/trace_buffer_pkg.sv
// -----------------------------------------------------------------------------
// trace_buffer_pkg
// Shared definitions for the CPU trace buffer (successor to the nic8 status
// monitor). An entry is packed as {tick, ctrl, dbus, regs}, with regs in the
// low bits. Field offsets and the entry width depend on the instance
// parameters, so they are provided as constant functions.
// -----------------------------------------------------------------------------
package trace_buffer_pkg;

    // Width of the nic8 control-bit vector (the `Control macro width).
    localparam int CTRL_BITS = 14;

    // Register channels always sit at the bottom of an entry.
    localparam int REGS_LSB = 0;

    // Buffer operation selected on each edge.
    // BUF_SHIFT advances both pointers with count unchanged. It covers two
    // cases: a simultaneous push and pop, and a push into a full buffer
    // that drops the oldest entry.
    typedef enum logic [1:0] {
        BUF_HOLD,
        BUF_PUSH,
        BUF_POP,
        BUF_SHIFT
    } buf_op_t;

    function automatic int dbus_lsb(input int width, input int num_regs);
        return REGS_LSB + num_regs * width;
    endfunction

    function automatic int ctrl_lsb(input int width, input int num_regs);
        return dbus_lsb(width, num_regs) + width;
    endfunction

    function automatic int tick_lsb(input int width, input int num_regs, input int ctrl_w);
        return ctrl_lsb(width, num_regs) + ctrl_w;
    endfunction

    function automatic int entry_w(input int width, input int num_regs,
                                   input int ctrl_w, input int tick_w);
        return tick_lsb(width, num_regs, ctrl_w) + tick_w;
    endfunction

endpackage

// File: rtl/trace_buffer_if.sv
// -----------------------------------------------------------------------------
// trace_buffer_if
// Valid/ready read port of the trace buffer.
//   rd_valid : buffer holds at least one entry (head is on rd_data)
//   rd_ready : consumer accepts the head entry this edge
//   rd_data  : head entry {tick, ctrl, dbus, regs}
// The master modport belongs to the buffer. The slave modport belongs to
// the consumer, which may be a UART dumper or a bench.
// -----------------------------------------------------------------------------
interface trace_buffer_if
    import trace_buffer_pkg::*;
#(
    parameter int ENTRY_W = entry_w(8, 6, CTRL_BITS, 16)
) ();

    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );

endinterface

// File: rtl/trace_buffer_ram.sv
// -----------------------------------------------------------------------------
// trace_ram
// Trace storage of DEPTH x WIDTH. It has one synchronous write port and one
// asynchronous read port. The asynchronous read lets the buffer head appear
// on the read port in the same cycle it is written, with no extra stage.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// -----------------------------------------------------------------------------
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 86
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
// Snapshots CPU state every clock into a circular trace memory. The memory
// is drained through a valid/ready read port.
//   clk, reset  : clock and synchronous active-high reset
//   regs        : NUM_REGS packed register channels (channel 0 = pc)
//   ctrl        : control bits of the current cycle
//   dbus        : data bus value
//   arm         : capture enabled while high
//   change_only : capture only when {regs,dbus} differ from the last capture
//   step_limit  : 0 = unlimited; otherwise halt once tick reaches this value
//   rd          : read port (rd_valid / rd_ready / rd_data = head entry)
//   count       : entries held
//   overflow    : sticky; an unread entry was overwritten
//   halt_req    : sticky; step limit reached
// -----------------------------------------------------------------------------
module trace_buffer
    import trace_buffer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int NUM_REGS = 6,
    parameter int CTRL_W   = CTRL_BITS,
    parameter int DEPTH    = 16,
    parameter int TICK_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REGS*WIDTH-1:0] regs,
    input  logic [CTRL_W-1:0]         ctrl,
    input  logic [WIDTH-1:0]          dbus,
    input  logic                      arm,
    input  logic                      change_only,
    input  logic [TICK_W-1:0]         step_limit,
    trace_buffer_if.master            rd,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic                      halt_req
);

    localparam int ENTRY_W = entry_w(WIDTH, NUM_REGS, CTRL_W, TICK_W);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CMP_W   = NUM_REGS * WIDTH + WIDTH;

    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [TICK_W-1:0] TICK_MAX = '1;

    logic [TICK_W-1:0]  tick;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               overflow_q;
    logic               halt_q;
    logic               first_q;
    logic               arm_q;
    logic [CMP_W-1:0]   last_cmp;

    logic [CMP_W-1:0]   cur_cmp;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] head;
    logic               arm_rise;
    logic               first_eff;
    logic               under_limit;
    logic               hit_limit;
    logic               changed;
    logic               capture;
    logic               full;
    logic               pop;
    buf_op_t            op;

    assign cur_cmp = {regs, dbus};
    assign entry   = {tick, ctrl, dbus, regs};

    // A rising arm counts as "first" on the same edge, so the arm edge
    // itself is always captured in change-only mode.
    assign arm_rise    = arm & ~arm_q;
    assign first_eff   = first_q | arm_rise;
    assign under_limit = (step_limit == '0) || (tick < step_limit);
    assign hit_limit   = (step_limit != '0) && (tick == step_limit);
    assign changed     = (cur_cmp != last_cmp);
    assign capture     = arm && !halt_q && under_limit &&
                         (!change_only || first_eff || changed);
    assign full        = (cnt == FULL_CNT);
    assign pop         = (cnt != '0) && rd.rd_ready;

    always_comb begin
        op = BUF_HOLD;
        if (capture && (pop || full)) begin
            op = BUF_SHIFT;
        end else if (capture) begin
            op = BUF_PUSH;
        end else if (pop) begin
            op = BUF_POP;
        end
    end

    // Control state: tick, pointers, occupancy and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            first_q    <= 1'b1;
            arm_q      <= 1'b0;
        end else begin
            if (tick != TICK_MAX) begin
                tick <= tick + TICK_W'(1);
            end
            arm_q <= arm;

            if (hit_limit) begin
                halt_q <= 1'b1;
            end

            if (capture) begin
                first_q <= 1'b0;
            end else if (arm_rise) begin
                first_q <= 1'b1;
            end

            case (op)
                BUF_PUSH: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    cnt    <= cnt + CNT_W'(1);
                end
                BUF_POP: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    cnt    <= cnt - CNT_W'(1);
                end
                BUF_SHIFT: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase

            // Full with no pop: the oldest entry is dropped to make room.
            if (capture && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Change-compare reference. The first flag masks its stale value after
    // reset, so it needs no reset of its own.
    always_ff @(posedge clk) begin
        if (capture) begin
            last_cmp <= cur_cmp;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata (entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign rd.rd_valid = (cnt != '0);
    assign rd.rd_data  = head;
    assign count       = cnt;
    assign overflow    = overflow_q;
    assign halt_req    = halt_q;

endmodule
